// File: rtl/mig7_traffic_pkg.sv
// Shared types, MIG command codes and the traffic pattern generator for mig7_traffic_engine.
package mig7_traffic_pkg;

  typedef enum logic [2:0] {IDLE, CALIB, WRITE, READ, DRAIN, FIN} state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Widest word the generator produces; callers size-cast down to their DATA_WIDTH.
  localparam int unsigned PAT_MAX_LANES = 32;
  localparam int unsigned PAT_MAX_W     = PAT_MAX_LANES * 32;

  // Lane k of word idx is seed ^ {idx, k}.
  function automatic logic [PAT_MAX_W-1:0] pattern_word(input logic [31:0] seed,
                                                        input logic [23:0] idx);
    logic [PAT_MAX_W-1:0] w;
    for (int k = 0; k < PAT_MAX_LANES; k++) begin
      w[k*32 +: 32] = seed ^ {idx, 8'(k)};
    end
    return w;
  endfunction

endpackage

// File: rtl/mig7_traffic_checker.sv
// In-order read-return checker: pattern compare, saturating error counter and, with
// MIG7_TRAFFIC_ERR_CAPTURE_EN defined, capture of the first mismatching word.
module mig7_traffic_checker
  import mig7_traffic_pkg::*;
#(
`ifdef MIG7_TRAFFIC_ERR_CAPTURE_EN
  parameter int unsigned ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned ADDR_STEP = 8,
`endif
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned SPAN_WORDS = 1024,
  parameter int unsigned ERR_WIDTH  = 32,
  parameter int unsigned CNT_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  active,
  input  logic [31:0]           seed,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
`ifdef MIG7_TRAFFIC_ERR_CAPTURE_EN
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] err_exp,
  output logic [DATA_WIDTH-1:0] err_got,
`endif
  output logic [CNT_W-1:0]      ret_count,
  output logic [ERR_WIDTH-1:0]  err_count
);

  logic [CNT_W-1:0]      qi_q;
  logic [ERR_WIDTH-1:0]  err_q;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  hit, miss, miss_q;

  assign exp_data = DATA_WIDTH'(pattern_word(seed, 24'(qi_q)));
  // Returns beyond the window are dropped so qi never runs past SPAN_WORDS.
  assign hit      = active && rd_valid && (qi_q != CNT_W'(SPAN_WORDS));
  assign miss     = hit && (rd_data != exp_data);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      qi_q   <= '0;
      miss_q <= 1'b0;
      err_q  <= '0;
    end else begin
      miss_q <= miss;
      if (hit) qi_q <= qi_q + CNT_W'(1);
      if (miss_q && (err_q != '1)) err_q <= err_q + ERR_WIDTH'(1);
    end
  end

  assign ret_count = qi_q;
  assign err_count = err_q;

`ifdef MIG7_TRAFFIC_ERR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] ret_addr_q;
  logic                  captured_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ret_addr_q <= BASE_ADDR;
      captured_q <= 1'b0;
      err_addr   <= '0;
      err_exp    <= '0;
      err_got    <= '0;
    end else begin
      if (hit) ret_addr_q <= ret_addr_q + ADDR_WIDTH'(ADDR_STEP);
      if (miss && !captured_q) begin
        captured_q <= 1'b1;
        err_addr   <= ret_addr_q;
        err_exp    <= exp_data;
        err_got    <= rd_data;
      end
    end
  end
`endif

endmodule

// File: rtl/mig7_traffic_engine.sv
// Write / read-back / compare traffic engine on the MIG7 app_* interface (ui_clk domain).
// Optional first-error capture ports with MIG7_TRAFFIC_ERR_CAPTURE_EN. DATA_WIDTH <= 1024.
module mig7_traffic_engine
  import mig7_traffic_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned SPAN_WORDS = 1024,
  parameter int unsigned ADDR_STEP  = 8,
  parameter int unsigned ERR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_WIDTH-1:0]    err_count,
`ifdef MIG7_TRAFFIC_ERR_CAPTURE_EN
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [DATA_WIDTH-1:0]   err_exp,
  output logic [DATA_WIDTH-1:0]   err_got,
`endif
  input  logic                    init_calib_complete,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_wren,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_end,
  input  logic                    app_rd_data_valid,
  input  logic                    app_rdy,
  input  logic                    app_wdf_rdy,
  output logic                    app_sr_req,
  output logic                    app_ref_req,
  output logic                    app_zq_req,
  input  logic                    app_sr_active,
  input  logic                    app_ref_ack,
  input  logic                    app_zq_ack
);

  localparam int unsigned CNT_W = $clog2(SPAN_WORDS + 1);

  state_t                state_q;
  logic [31:0]           seed_q;
  logic [CNT_W-1:0]      wi_q, ri_q, qi;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            cmd_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  en_q, wren_q, busy_q, done_q, pass_q;
  logic                  start_acc, chk_active, word_done;
  logic [ERR_WIDTH-1:0]  err_cnt;
  logic                  unused_inputs;

  assign start_acc  = (state_q == IDLE) && start;
  assign chk_active = (state_q == READ) || (state_q == DRAIN);
  // Word completes once neither the command nor the data beat is left pending.
  assign word_done  = (!en_q || app_rdy) && (!wren_q || app_wdf_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seed_q  <= '0;
      wi_q    <= '0;
      ri_q    <= '0;
      addr_q  <= '0;
      cmd_q   <= '0;
      wdata_q <= '0;
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            seed_q  <= seed;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            state_q <= CALIB;
          end
        end
        CALIB: begin
          if (init_calib_complete) begin
            wi_q    <= '0;
            addr_q  <= BASE_ADDR;
            cmd_q   <= CMD_WRITE;
            wdata_q <= DATA_WIDTH'(pattern_word(seed_q, 24'd0));
            en_q    <= 1'b1;
            wren_q  <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (word_done) begin
            if (wi_q == CNT_W'(SPAN_WORDS - 1)) begin
              ri_q    <= '0;
              addr_q  <= BASE_ADDR;
              cmd_q   <= CMD_READ;
              en_q    <= 1'b1;
              wren_q  <= 1'b0;
              state_q <= READ;
            end else begin
              wi_q    <= wi_q + CNT_W'(1);
              addr_q  <= addr_q + ADDR_WIDTH'(ADDR_STEP);
              wdata_q <= DATA_WIDTH'(pattern_word(seed_q, 24'(wi_q + CNT_W'(1))));
              en_q    <= 1'b1;
              wren_q  <= 1'b1;
            end
          end else begin
            en_q   <= en_q && !app_rdy;
            wren_q <= wren_q && !app_wdf_rdy;
          end
        end
        READ: begin
          if (app_rdy) begin
            if (ri_q == CNT_W'(SPAN_WORDS - 1)) begin
              en_q    <= 1'b0;
              state_q <= DRAIN;
            end else begin
              ri_q   <= ri_q + CNT_W'(1);
              addr_q <= addr_q + ADDR_WIDTH'(ADDR_STEP);
            end
          end
        end
        DRAIN: begin
          if (qi == CNT_W'(SPAN_WORDS)) state_q <= FIN;
        end
        FIN: begin
          // err_count has absorbed the last registered compare by now.
          done_q  <= 1'b1;
          pass_q  <= (err_cnt == '0);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mig7_traffic_checker #(
`ifdef MIG7_TRAFFIC_ERR_CAPTURE_EN
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_STEP  (ADDR_STEP),
`endif
    .DATA_WIDTH (DATA_WIDTH),
    .SPAN_WORDS (SPAN_WORDS),
    .ERR_WIDTH  (ERR_WIDTH),
    .CNT_W      (CNT_W)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc),
    .active    (chk_active),
    .seed      (seed_q),
    .rd_data   (app_rd_data),
    .rd_valid  (app_rd_data_valid),
`ifdef MIG7_TRAFFIC_ERR_CAPTURE_EN
    .err_addr  (err_addr),
    .err_exp   (err_exp),
    .err_got   (err_got),
`endif
    .ret_count (qi),
    .err_count (err_cnt)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_cnt;
  assign app_addr     = addr_q;
  assign app_cmd      = cmd_q;
  assign app_en       = en_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wren_q;
  assign app_wdf_mask = '0;
  assign app_sr_req   = 1'b0;
  assign app_ref_req  = 1'b0;
  assign app_zq_req   = 1'b0;

  assign unused_inputs = ^{app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack};

endmodule
